mlp_param_loader: RTL
=====================

# mlp_param_loader

Streams weight and bias words into the two MLP layers (4×6 input layer, 2×4 output layer) over a valid/ready word interface. It writes each word through a registered memory write port and asserts `load_done` to release the network once all parameters are written. It is the writer counterpart of the layer parameter memories. At power-up it replaces file preloading, so parameters can be loaded at run time.

## Interface
Parameters:
- `DATA_W`, 32, parameter word width
- `L0_WEIGHTS`, 24, input-layer weight count
- `L0_BIASES`, 4, input-layer bias count
- `L1_WEIGHTS`, 8, output-layer weight count
- `L1_BIASES`, 2, output-layer bias count
- `ADDR_W`, 5, write address width; must satisfy 2^ADDR_W ≥ largest count

Ports:
- `CLK`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a load
- `in_data`  in  DATA_W  parameter word
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a word this cycle
- `wr_en`  out  1  write strobe
- `wr_layer`  out  1  0 = input layer, 1 = output layer
- `wr_bias`  out  1  0 = weight memory, 1 = bias memory
- `wr_addr`  out  ADDR_W  word index within the selected memory
- `wr_data`  out  DATA_W  word to write
- `busy`  out  1  load in progress
- `load_done`  out  1  all parameters written; drives the first layer's enable
- `chk_err`  out  1  checksum mismatch (checksum build only; tied 0 otherwise)

## Operation
- States: IDLE, L0_W, L0_B, L1_W, L1_B, CHK (checksum build only), DONE.
- IDLE:
  - `start` → L0_W.
  - Clear the address counter, `load_done` and `chk_err`.
- DONE:
  - `load_done` = 1 and is held.
  - `start` → L0_W, and `load_done` drops in the same transition.
- Handshake:
  - `in_ready` = 1 exactly in L0_W, L0_B, L1_W, L1_B and CHK.
  - A word is accepted when `in_valid && in_ready`.
  - `in_valid` may deassert at any time; idle cycles produce no write.
- Each accepted word in a loading state increments the address counter. On the count (L0_WEIGHTS, L0_BIASES, L1_WEIGHTS or L1_BIASES) minus 1, the counter returns to 0 and the state advances.
- Stream order: L0 weights, L0 biases, L1 weights, L1 biases. The default total is 38 words.
- Write mapping: state L0_* gives `wr_layer`=0 and L1_* gives 1; state *_B gives `wr_bias`=1. `wr_addr` is the counter value at acceptance.
- After the last L1 bias: go to CHK in the checksum build, otherwise to DONE.
- `start` is ignored in every state except IDLE and DONE.
- `busy` = 1 in every state except IDLE and DONE.
- Reset (any time, including mid-load):
  - state = IDLE.
  - All outputs 0: `in_ready`, `wr_en`, `wr_layer`, `wr_bias`, `wr_addr`, `wr_data`, `busy`, `load_done`, `chk_err`.
  - Memory contents after a partial load are undefined. The network stays disabled until a full load completes.

## Timing
- Write port is registered. A word accepted at edge N produces `wr_en`=1 with its `wr_layer`/`wr_bias`/`wr_addr`/`wr_data` during cycle N+1. Otherwise `wr_en` = 0.
- `load_done` rises one cycle after the final `wr_en` pulse, so the last write has committed before the layers start.
- With continuous `in_valid`: `start` at edge S gives the first accept at S+1 and `load_done` high at S+40 (default counts, no checksum).
- `start` in DONE: `load_done` falls at the next edge and `in_ready` rises at the same edge.

## Configuration
- Macro `MLP_PARAM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - A running XOR is computed over all accepted parameter words.
  - One extra trailing word is accepted in CHK. It produces no write.
  - The state then goes to DONE. `chk_err` = 1 if the trailing word ≠ the running XOR, otherwise 0.
  - `load_done` asserts regardless of the result. Gating the network on `chk_err` is the integrator's choice.
  - `chk_err` holds until the next `start` or reset.
- **Undefined:** no CHK state, no XOR register, and `chk_err` is tied 0.

## Structure
- Shared package `mlp_pkg`:
  - state enum `loader_state_t`
  - `DATA_W`
  - default layer shape constants (neurons, inputs, weights per layer)
  - layer-select and memory-select encodings
- No sub-module. This is a single FSM plus counter plus output register. The checksum is inline under the macro.

## Test plan
- **Basic load:** `start`, then 38 words of value i+1 back-to-back → writes to (layer, bias, addr):
  - (0,0,0..23) with data 1..24
  - (0,1,0..3) with data 25..28
  - (1,0,0..7) with data 29..36
  - (1,1,0..1) with data 37..38
  - `load_done` first high 40 cycles after `start`.
- **Backpressure:** same stream with `in_valid` low on every third cycle → identical write sequence, no writes during gaps, `load_done` one cycle after the last write.
- **Start while busy:** pulse `start` after word 10 → no restart; addresses continue 10, 11, …; exactly 38 writes.
- **Reset mid-load:** drop `reset` after word 20 → all outputs 0 immediately; after release, a fresh `start` plus 38 words completes normally.
- **Checksum (macro defined):**
  - Trailing word = XOR of 1..38 (0x27) → `chk_err`=0, `load_done`=1.
  - Trailing word 0x00 → `chk_err`=1.
  - Neither trailing word produces a `wr_en`.
- **Reload:** `start` in DONE → `load_done` drops the next cycle; a second full stream rewrites all 38 locations and `load_done` reasserts.

Source files
------------

// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared MLP types, layer shapes and parameter-memory select encodings.
package mlp_pkg;

  localparam int DATA_W = 32;

  localparam int L0_NEURONS = 4;
  localparam int L0_INPUTS  = 6;
  localparam int L1_NEURONS = 2;
  localparam int L1_INPUTS  = 4;

  localparam int L0_WEIGHTS_DEF = L0_NEURONS * L0_INPUTS;
  localparam int L0_BIASES_DEF  = L0_NEURONS;
  localparam int L1_WEIGHTS_DEF = L1_NEURONS * L1_INPUTS;
  localparam int L1_BIASES_DEF  = L1_NEURONS;

  localparam logic LAYER_IN   = 1'b0;
  localparam logic LAYER_OUT  = 1'b1;
  localparam logic MEM_WEIGHT = 1'b0;
  localparam logic MEM_BIAS   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    L0_W,
    L0_B,
    L1_W,
    L1_B,
    CHK,
    DONE
  } loader_state_t;

  function automatic logic state_layer(loader_state_t s);
    return (s == L1_W || s == L1_B) ? LAYER_OUT : LAYER_IN;
  endfunction

  function automatic logic state_bias(loader_state_t s);
    return (s == L0_B || s == L1_B) ? MEM_BIAS : MEM_WEIGHT;
  endfunction

endpackage

// File: rtl/mlp_param_loader_if.sv
// rtl/mlp_param_loader_if.sv - parameter word stream in, registered memory write port out.
interface mlp_param_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic              wr_layer;
  logic              wr_bias;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // master is the loader: it owns in_ready and the write port
  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_layer, wr_bias, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_layer, wr_bias, wr_addr, wr_data
  );
endinterface

// File: rtl/mlp_param_loader.sv
// rtl/mlp_param_loader.sv - streams MLP weights/biases into layer memories; MLP_PARAM_LOADER_CHECKSUM_EN adds a trailing XOR check word.
module mlp_param_loader
  import mlp_pkg::*;
#(
  parameter int DATA_W     = mlp_pkg::DATA_W,
  parameter int L0_WEIGHTS = mlp_pkg::L0_WEIGHTS_DEF,
  parameter int L0_BIASES  = mlp_pkg::L0_BIASES_DEF,
  parameter int L1_WEIGHTS = mlp_pkg::L1_WEIGHTS_DEF,
  parameter int L1_BIASES  = mlp_pkg::L1_BIASES_DEF,
  parameter int ADDR_W     = 5
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  mlp_param_loader_if.master   bus,
  output logic                 busy,
  output logic                 load_done,
  output logic                 chk_err
);

  localparam logic [ADDR_W-1:0] L0W_LAST = ADDR_W'(L0_WEIGHTS - 1);
  localparam logic [ADDR_W-1:0] L0B_LAST = ADDR_W'(L0_BIASES - 1);
  localparam logic [ADDR_W-1:0] L1W_LAST = ADDR_W'(L1_WEIGHTS - 1);
  localparam logic [ADDR_W-1:0] L1B_LAST = ADDR_W'(L1_BIASES - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_layer_q, wr_layer_d;
  logic              wr_bias_q, wr_bias_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              accept;
  logic [ADDR_W-1:0] last_idx;
  loader_state_t     next_seg;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              chk_err_q, chk_err_d;
`endif

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_layer_d  = wr_layer_q;
    wr_bias_d   = wr_bias_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    last_idx    = '0;
    next_seg    = DONE;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
    chk_err_d   = chk_err_q;
`endif

    case (state_q)
      L0_W: begin last_idx = L0W_LAST; next_seg = L0_B; end
      L0_B: begin last_idx = L0B_LAST; next_seg = L1_W; end
      L1_W: begin last_idx = L1W_LAST; next_seg = L1_B; end
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
      L1_B: begin last_idx = L1B_LAST; next_seg = CHK; end
`else
      L1_B: begin last_idx = L1B_LAST; next_seg = DONE; end
`endif
      default: begin last_idx = '0; next_seg = DONE; end
    endcase

    case (state_q)
      IDLE, DONE: begin
        cnt_d = '0;
        if (start) begin
          state_d = L0_W;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
          xor_d     = '0;
          chk_err_d = 1'b0;
`endif
        end
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
        if (state_q == IDLE) chk_err_d = 1'b0;
`endif
      end
      L0_W, L0_B, L1_W, L1_B: begin
        if (accept) begin
          wr_en_d    = 1'b1;
          wr_layer_d = state_layer(state_q);
          wr_bias_d  = state_bias(state_q);
          wr_addr_d  = cnt_q;
          wr_data_d  = bus.in_data;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ bus.in_data;
`endif
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = next_seg;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
      CHK: begin
        // Trailing check word is compared only, never written
        if (accept) begin
          chk_err_d = (bus.in_data != xor_q);
          state_d   = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == L0_W) || (state_d == L0_B) || (state_d == L1_W) ||
                  (state_d == L1_B) || (state_d == CHK);
    busy_d      = in_ready_d;
    // Wait out the final write pulse so the last word has committed first
    load_done_d = (state_q == DONE) && (state_d == DONE) && !wr_en_q;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_layer_q  <= 1'b0;
      wr_bias_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
      xor_q       <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_layer_q  <= wr_layer_d;
      wr_bias_q   <= wr_bias_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_layer = wr_layer_q;
  assign bus.wr_bias  = wr_bias_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign load_done    = load_done_q;
`ifdef MLP_PARAM_LOADER_CHECKSUM_EN
  assign chk_err      = chk_err_q;
`else
  assign chk_err      = 1'b0;
`endif

endmodule
